// File: rtl/duck_scheduler.sv
// duck_scheduler: paces duck spawns, lifetimes and hit flashes during GAME.
// Tracks per-round score and misses for the SCORE screen.
module duck_scheduler #(
  parameter int TICK_DIV        = 65000,
  parameter int GAP_MS          = 500,
  parameter int LIFE_MS         = 1500,
  parameter int FLASH_MS        = 200,
  parameter int DUCKS_PER_ROUND = 10,
  parameter int XPOS_MAX        = 960,
  parameter int YPOS_MAX        = 704
) (
  input  logic        pclk,
  input  logic        rst_d,
  input  logic [1:0]  state_in,
  input  logic        duck_hit,
  output logic        duck_visible,
  output logic        duck_hit_flag,
  output logic [10:0] duck_xpos,
  output logic [10:0] duck_ypos,
  output logic        spawn_pulse,
  output logic [7:0]  score,
  output logic [7:0]  misses,
  output logic        round_done
);

  typedef enum logic [2:0] {
    S_OFF,
    S_GAP,
    S_ACTIVE,
    S_FLASH,
    S_DONE
  } state_t;

  localparam logic [16:0] PRESC_TOP = 17'(TICK_DIV - 1);
  localparam logic [11:0] GAP_TOP   = 12'(GAP_MS - 1);
  localparam logic [11:0] LIFE_TOP  = 12'(LIFE_MS - 1);
  localparam logic [11:0] FLASH_TOP = 12'(FLASH_MS - 1);
  localparam logic [7:0]  DUCKS     = 8'(DUCKS_PER_ROUND);
  localparam logic [9:0]  XMAX      = 10'(XPOS_MAX);
  localparam logic [9:0]  YMAX      = 10'(YPOS_MAX);

  state_t      state;
  state_t      state_nxt;
  logic [16:0] presc;
  logic [11:0] ms_cnt;
  logic [7:0]  duck_cnt;
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;
  logic [9:0]  lx;
  logic [9:0]  ly;
  logic [9:0]  fx;
  logic [9:0]  fy;
  logic        game;
  logic        tick;
  logic        last_duck;
  logic        gap_end;
  logic        life_end;
  logic        flash_end;

  assign game      = (state_in == 2'b10);
  assign tick      = (presc == PRESC_TOP);
  assign gap_end   = tick && (ms_cnt == GAP_TOP);
  assign life_end  = tick && (ms_cnt == LIFE_TOP);
  assign flash_end = tick && (ms_cnt == FLASH_TOP);
  assign last_duck = (duck_cnt == DUCKS);

  // Galois form of x^16+x^14+x^13+x^11+1
  assign lfsr_nxt = {1'b0, lfsr[15:1]}
                  ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // Fold keeps positions on screen: 1023-512 never exceeds MAX
  assign lx = lfsr[9:0];
  assign ly = lfsr[15:6];
  assign fx = (lx > XMAX) ? lx - XMAX : lx;
  assign fy = (ly > YMAX) ? ly - YMAX : ly;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_OFF:    state_nxt = S_GAP;
      S_GAP:    if (gap_end) state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (duck_hit) state_nxt = S_FLASH;
        else if (life_end)
          state_nxt = last_duck ? S_DONE : S_GAP;
      end
      S_FLASH: begin
        if (flash_end)
          state_nxt = last_duck ? S_DONE : S_GAP;
      end
      S_DONE:   state_nxt = S_DONE;
      default:  state_nxt = S_OFF;
    endcase
    if (!game) state_nxt = S_OFF;
  end

  always_ff @(posedge pclk or posedge rst_d) begin
    if (rst_d) begin
      state         <= S_OFF;
      presc         <= '0;
      ms_cnt        <= '0;
      duck_cnt      <= '0;
      lfsr          <= 16'hACE1;
      duck_visible  <= 1'b0;
      duck_hit_flag <= 1'b0;
      duck_xpos     <= '0;
      duck_ypos     <= '0;
      spawn_pulse   <= 1'b0;
      score         <= '0;
      misses        <= '0;
      round_done    <= 1'b0;
    end else begin
      lfsr        <= lfsr_nxt;
      state       <= state_nxt;
      spawn_pulse <= 1'b0;

      if (state_nxt != state) begin
        presc  <= '0;
        ms_cnt <= '0;
      end else if (tick) begin
        presc  <= '0;
        ms_cnt <= ms_cnt + 12'd1;
      end else begin
        presc  <= presc + 17'd1;
      end

      if (state == S_OFF && state_nxt == S_GAP) begin
        score    <= '0;
        misses   <= '0;
        duck_cnt <= '0;
      end

      if (state == S_GAP && state_nxt == S_ACTIVE) begin
        duck_xpos   <= {1'b0, fx};
        duck_ypos   <= {1'b0, fy};
        spawn_pulse <= 1'b1;
        duck_cnt    <= duck_cnt + 8'd1;
      end

      if (state == S_ACTIVE && state_nxt == S_FLASH) begin
        if (score != 8'hFF) score <= score + 8'd1;
      end

      // leaving ACTIVE to GAP/DONE only happens on timeout
      if (state == S_ACTIVE &&
          (state_nxt == S_GAP || state_nxt == S_DONE)) begin
        if (misses != 8'hFF) misses <= misses + 8'd1;
      end

      duck_visible  <= (state_nxt == S_ACTIVE) ||
                       (state_nxt == S_FLASH);
      duck_hit_flag <= (state_nxt == S_FLASH);
      round_done    <= (state_nxt == S_DONE);
    end
  end

endmodule

// File: tb/tb_duck_scheduler.sv
// tb_duck_scheduler: two scheduler configs against a phase/countdown model.
// Directed round scenarios plus random game/hit traffic.
module tb_duck_scheduler;

  localparam logic [1:0] GAME = 2'b10;
  localparam int P_OFF  = 0;
  localparam int P_GAP  = 1;
  localparam int P_ACT  = 2;
  localparam int P_FL   = 3;
  localparam int P_DONE = 4;

  typedef struct packed {
    int          ph;
    int          rem;
    int          score;
    int          misses;
    int          ducks;
    logic [15:0] lfsr;
    int          x;
    int          y;
    logic        vis;
    logic        flag;
    logic        spawn;
    logic        done;
  } mdl_t;

  logic        pclk;
  logic        rst_d;
  logic [1:0]  state_in;
  logic        hit_a;
  logic        hit_b;
  logic        force_b;

  logic        vis_a, flag_a, spawn_a, done_a;
  logic [10:0] x_a, y_a;
  logic [7:0]  score_a, misses_a;
  logic        vis_b, flag_b, spawn_b, done_b;
  logic [10:0] x_b, y_b;
  logic [7:0]  score_b, misses_b;

  int tests;
  int fails;
  mdl_t ma;
  mdl_t mb;

  duck_scheduler #(
    .TICK_DIV(4), .GAP_MS(2), .LIFE_MS(3), .FLASH_MS(1),
    .DUCKS_PER_ROUND(2), .XPOS_MAX(960), .YPOS_MAX(704)
  ) u_a (
    .pclk(pclk), .rst_d(rst_d), .state_in(state_in),
    .duck_hit(hit_a), .duck_visible(vis_a),
    .duck_hit_flag(flag_a), .duck_xpos(x_a),
    .duck_ypos(y_a), .spawn_pulse(spawn_a),
    .score(score_a), .misses(misses_a),
    .round_done(done_a)
  );

  duck_scheduler #(
    .TICK_DIV(2), .GAP_MS(1), .LIFE_MS(2), .FLASH_MS(1),
    .DUCKS_PER_ROUND(255), .XPOS_MAX(512), .YPOS_MAX(600)
  ) u_b (
    .pclk(pclk), .rst_d(rst_d), .state_in(state_in),
    .duck_hit(hit_b), .duck_visible(vis_b),
    .duck_hit_flag(flag_b), .duck_xpos(x_b),
    .duck_ypos(y_b), .spawn_pulse(spawn_b),
    .score(score_b), .misses(misses_b),
    .round_done(done_b)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  function automatic logic [15:0] lfsr_step(logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int fold(int v, int mx);
    return (v > mx) ? v - mx : v;
  endfunction

  function automatic mdl_t mreset();
    mdl_t n;
    n      = '0;
    n.ph   = P_OFF;
    n.lfsr = 16'hACE1;
    return n;
  endfunction

  function automatic int sat(int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit game, bit hit,
      int td, int gap, int life, int fl, int nd, int xm, int ym);
    mdl_t n;
    n       = m;
    n.lfsr  = lfsr_step(m.lfsr);
    n.spawn = 1'b0;
    if (!game) n.ph = P_OFF;
    else begin
      case (m.ph)
        P_OFF: begin
          n.ph = P_GAP; n.rem = gap * td;
          n.score = 0; n.misses = 0; n.ducks = 0;
        end
        P_GAP: begin
          n.rem = m.rem - 1;
          if (n.rem == 0) begin
            n.ph    = P_ACT;
            n.rem   = life * td;
            n.x     = fold(int'(m.lfsr[9:0]), xm);
            n.y     = fold(int'(m.lfsr[15:6]), ym);
            n.spawn = 1'b1;
            n.ducks = m.ducks + 1;
          end
        end
        P_ACT: begin
          if (hit) begin
            n.ph = P_FL; n.rem = fl * td;
            n.score = sat(m.score);
          end else begin
            n.rem = m.rem - 1;
            if (n.rem == 0) begin
              n.misses = sat(m.misses);
              n.ph  = (m.ducks == nd) ? P_DONE : P_GAP;
              n.rem = gap * td;
            end
          end
        end
        P_FL: begin
          n.rem = m.rem - 1;
          if (n.rem == 0) begin
            n.ph  = (m.ducks == nd) ? P_DONE : P_GAP;
            n.rem = gap * td;
          end
        end
        default: ;
      endcase
    end
    n.vis  = (n.ph == P_ACT) || (n.ph == P_FL);
    n.flag = (n.ph == P_FL);
    n.done = (n.ph == P_DONE);
    return n;
  endfunction

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all(string t, mdl_t m,
      logic v, logic f, logic [10:0] x, logic [10:0] y,
      logic sp, logic [7:0] sc, logic [7:0] ms, logic d,
      int xm, int ym);
    chk({t, ".vis"}, int'(v), int'(m.vis));
    chk({t, ".flag"}, int'(f), int'(m.flag));
    chk({t, ".spawn"}, int'(sp), int'(m.spawn));
    chk({t, ".done"}, int'(d), int'(m.done));
    chk({t, ".score"}, int'(sc), m.score);
    chk({t, ".misses"}, int'(ms), m.misses);
    chk({t, ".x"}, int'(x), m.x);
    chk({t, ".y"}, int'(y), m.y);
    if (v) begin
      chk({t, ".xbound"}, int'(int'(x) <= xm), 1);
      chk({t, ".ybound"}, int'(int'(y) <= ym), 1);
    end
  endtask

  task automatic zero_chk(string t);
    chk({t, ".a_vis"}, int'(vis_a), 0);
    chk({t, ".a_flag"}, int'(flag_a), 0);
    chk({t, ".a_x"}, int'(x_a), 0);
    chk({t, ".a_y"}, int'(y_a), 0);
    chk({t, ".a_spawn"}, int'(spawn_a), 0);
    chk({t, ".a_score"}, int'(score_a), 0);
    chk({t, ".a_misses"}, int'(misses_a), 0);
    chk({t, ".a_done"}, int'(done_a), 0);
    chk({t, ".b_vis"}, int'(vis_b), 0);
    chk({t, ".b_score"}, int'(score_b), 0);
    chk({t, ".b_done"}, int'(done_b), 0);
  endtask

  always @(posedge pclk or posedge rst_d) begin
    if (rst_d) begin
      ma = mreset();
      mb = mreset();
    end else begin
      ma = mstep(ma, state_in == GAME, hit_a,
                 4, 2, 3, 1, 2, 960, 704);
      mb = mstep(mb, state_in == GAME, hit_b,
                 2, 1, 2, 1, 255, 512, 600);
    end
  end

  always @(negedge pclk) begin
    if (!rst_d) begin
      cmp_all("A", ma, vis_a, flag_a, x_a, y_a, spawn_a,
              score_a, misses_a, done_a, 960, 704);
      cmp_all("B", mb, vis_b, flag_b, x_b, y_b, spawn_b,
              score_b, misses_b, done_b, 512, 600);
    end
  end

  initial begin
    hit_b = 1'b0;
    forever begin
      @(negedge pclk);
      hit_b = force_b ? 1'b1 : ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    int fl;
    int n;
    tests = 0; fails = 0;
    rst_d = 1'b1; state_in = 2'b00;
    hit_a = 1'b0; force_b = 1'b0;
    repeat (3) @(negedge pclk);
    zero_chk("reset");
    rst_d = 1'b0;
    repeat (2) @(negedge pclk);

    // two ducks, no hits
    state_in = GAME;
    for (int k = 0; k < 46; k++) begin
      @(posedge pclk); #1;
      chk("s1.spawn", int'(spawn_a), int'(k == 8 || k == 28));
      chk("s1.done", int'(done_a), int'(k >= 40));
      if (k >= 40) chk("s1.vis", int'(vis_a), 0);
      @(negedge pclk);
    end
    chk("s1.misses", int'(misses_a), 2);
    chk("s1.score", int'(score_a), 0);
    state_in = 2'b00;
    repeat (3) @(negedge pclk);
    chk("off.misses_hold", int'(misses_a), 2);
    chk("off.done", int'(done_a), 0);

    // hit 5 cycles into the first duck
    state_in = GAME; fl = 0;
    for (int k = 0; k < 60; k++) begin
      hit_a = (k == 13);
      @(posedge pclk); #1;
      fl += int'(flag_a);
      @(negedge pclk);
    end
    hit_a = 1'b0;
    chk("s2.flash_len", fl, 4);
    chk("s2.score", int'(score_a), 1);
    chk("s2.misses", int'(misses_a), 1);
    chk("s2.done", int'(done_a), 1);
    state_in = 2'b00;
    repeat (3) @(negedge pclk);

    // hit on the timeout tick, then leave GAME mid-ACTIVE
    state_in = GAME;
    for (int k = 0; k < 36; k++) begin
      hit_a = (k == 20);
      if (k == 35) state_in = 2'b00;
      @(posedge pclk); #1;
      if (k == 20) begin
        chk("s3.flag", int'(flag_a), 1);
        chk("s3.score", int'(score_a), 1);
        chk("s3.misses", int'(misses_a), 0);
      end
      if (k == 34) chk("s4.vis_before", int'(vis_a), 1);
      if (k == 35) begin
        chk("s4.vis_after", int'(vis_a), 0);
        chk("s4.score_kept", int'(score_a), 1);
      end
      @(negedge pclk);
    end
    hit_a = 1'b0;
    repeat (3) @(negedge pclk);
    chk("s4.score_off", int'(score_a), 1);
    state_in = GAME;
    for (int k = 0; k < 10; k++) begin
      @(posedge pclk); #1;
      chk("s4.respawn", int'(spawn_a), int'(k == 8));
      if (k == 0) begin
        chk("s4.score_clr", int'(score_a), 0);
        chk("s4.misses_clr", int'(misses_a), 0);
      end
      @(negedge pclk);
    end

    // random game/hit traffic
    for (int k = 0; k < 600; k++) begin
      state_in = ($urandom_range(0, 9) == 0) ?
                 2'($urandom_range(0, 3)) : GAME;
      hit_a = ($urandom_range(0, 3) == 0);
      @(negedge pclk);
    end
    hit_a = 1'b0;

    // every duck of a 255-duck round is hit
    state_in = 2'b00;
    repeat (3) @(negedge pclk);
    force_b = 1'b1;
    state_in = GAME;
    repeat (2) @(negedge pclk);
    n = 0;
    while (!done_b && n < 4000) begin
      @(negedge pclk);
      n++;
    end
    chk("sat.done", int'(done_b), 1);
    chk("sat.score", int'(score_b), 255);
    chk("sat.misses", int'(misses_b), 0);
    force_b = 1'b0;

    // async reset mid-FLASH
    state_in = 2'b00;
    repeat (3) @(negedge pclk);
    state_in = GAME;
    for (int k = 0; k < 15; k++) begin
      hit_a = (k == 13);
      @(posedge pclk);
      @(negedge pclk);
    end
    hit_a = 1'b0;
    chk("rst.pre_flag", int'(flag_a), 1);
    #2 rst_d = 1'b1;
    #1 zero_chk("async_rst");
    @(negedge pclk);
    rst_d = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge pclk); #1;
      chk("rst.spawn", int'(spawn_a), int'(k == 8));
      if (k == 8) begin
        chk("rst.x", int'(x_a), 708);
        chk("rst.y", int'(y_a), 75);
      end
      @(negedge pclk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
